// File: rtl/juego_param_if.sv
// Frogger core I/O bundle: debounced button pulses and level in; painted field and game status out.
interface juego_param_if #(
  parameter int COLS   = 8,
  parameter int ROWS   = 8,
  parameter int LIVES  = 3,
  parameter int SCOREW = 4
);
  logic                       JP_START, JP_LEFT, JP_RIGHT, JP_UP, JP_DOWN;
  logic [1:0]                 JP_LEVEL;
  logic [ROWS*COLS-1:0]       JP_MATRIX_OUT;
  logic [2:0]                 JP_STATE_OUT;
  logic [$clog2(COLS)-1:0]    JP_POSX_OUT;
  logic [$clog2(ROWS)-1:0]    JP_POSY_OUT;
  logic [$clog2(LIVES+1)-1:0] JP_LIVES_OUT;
  logic [SCOREW-1:0]          JP_SCORE_OUT;

  modport master (
    output JP_START, JP_LEFT, JP_RIGHT, JP_UP, JP_DOWN, JP_LEVEL,
    input  JP_MATRIX_OUT, JP_STATE_OUT, JP_POSX_OUT, JP_POSY_OUT, JP_LIVES_OUT, JP_SCORE_OUT
  );
  modport slave (
    input  JP_START, JP_LEFT, JP_RIGHT, JP_UP, JP_DOWN, JP_LEVEL,
    output JP_MATRIX_OUT, JP_STATE_OUT, JP_POSX_OUT, JP_POSY_OUT, JP_LIVES_OUT, JP_SCORE_OUT
  );
endinterface

// File: rtl/juego_param.sv
// Parametrised Frogger core: rotating vehicle lanes, frog, houses, lives/score and game FSM,
// with a registered, painted ROWSxCOLS matrix.
module juego_lane #(
  parameter int COLS     = 8,
  parameter bit ROT_LEFT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            clr_i,
  input  logic            tick_i,
  input  logic [COLS-1:0] seed_i,
  input  logic [2:0]      period_i,
  output logic [COLS-1:0] lane_o,
  output logic [COLS-1:0] lane_nx_o
);
  logic [COLS-1:0] lane_q, lane_d;
  logic [2:0]      cnt_q, cnt_d;

  always_comb begin
    lane_d = lane_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      lane_d = seed_i;
      cnt_d  = '0;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q >= period_i - 3'd1) begin
        cnt_d  = '0;
        lane_d = ROT_LEFT ? {lane_q[COLS-2:0], lane_q[COLS-1]} : {lane_q[0], lane_q[COLS-1:1]};
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lane_q <= '0;
      cnt_q  <= '0;
    end else begin
      lane_q <= lane_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lane_o    = lane_q;
  assign lane_nx_o = lane_d;
endmodule

module juego_param #(
  parameter int              COLS      = 8,
  parameter int              ROWS      = 8,
  parameter int              LIVES     = 3,
  parameter int              TICK_DIV  = 25000000,
  parameter logic [COLS-1:0] LANE_INIT = COLS'(3),
  parameter int              SCOREW    = 4
) (
  input logic          JP_CLOCK,
  input logic          JP_RESET,
  juego_param_if.slave jp
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int LW = $clog2(LIVES + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  function automatic logic [COLS-1:0] even_cols();
    even_cols = '0;
    for (int i = 0; i < COLS; i += 2) even_cols[i] = 1'b1;
  endfunction
  localparam logic [COLS-1:0] EVEN = even_cols();

  typedef enum logic [2:0] {S_IDLE = 3'd0, S_PLAY = 3'd1, S_DIE = 3'd2, S_WIN = 3'd3, S_LOSE = 3'd4} state_e;

  state_e                    state_q, state_d;
  logic [PW-1:0]             presc_q, presc_d;
  logic [XW-1:0]             posx_q, posx_d;
  logic [YW-1:0]             posy_q, posy_d;
  logic [LW-1:0]             lives_q, lives_d;
  logic [SCOREW-1:0]         score_q, score_d;
  logic [COLS-1:0]           houses_q, houses_d;
  logic [1:0]                level_q, level_d;
  logic                      blink_q, blink_d;
  logic [ROWS*COLS-1:0]      mat_q, mat_d;
  logic [ROWS-1:0][COLS-1:0] lane_q, lane_d, rows;
  logic                      run, tick, load, clr, one_mv, at_home, home_ok, collide;
  logic [3:0]                mv;

  // Start and house rows carry no vehicles, so their lane slots stay zero.
  assign lane_q[0]      = '0;
  assign lane_d[0]      = '0;
  assign lane_q[ROWS-1] = '0;
  assign lane_d[ROWS-1] = '0;

  for (genvar r = 1; r <= ROWS - 2; r++) begin : g_lane
    localparam int              SH   = r % COLS;
    localparam logic [COLS-1:0] SEED = (LANE_INIT << SH) | (LANE_INIT >> ((COLS - SH) % COLS));
    logic [2:0] period;
    assign period = 3'd1 + 3'((r - 1) % 2) + (3'd3 - {1'b0, level_q});
    juego_lane #(.COLS(COLS), .ROT_LEFT((r % 2) == 1)) u_lane (
      .clk_i    (JP_CLOCK),
      .rst_ni   (JP_RESET),
      .load_i   (load),
      .clr_i    (clr),
      .tick_i   (tick && state_q == S_PLAY),
      .seed_i   (SEED),
      .period_i (period),
      .lane_o   (lane_q[r]),
      .lane_nx_o(lane_d[r])
    );
  end

  // Prescaler also runs in DIE (its length is one tick) and LOSE (frog blink).
  assign run     = state_q inside {S_PLAY, S_DIE, S_LOSE};
  assign tick    = run && (presc_q == PW'(TICK_DIV - 1));
  assign mv      = {jp.JP_LEFT, jp.JP_RIGHT, jp.JP_UP, jp.JP_DOWN};
  assign one_mv  = (mv != 4'b0) && ((mv & (mv - 4'd1)) == 4'b0);
  assign at_home = posy_q == YW'(ROWS - 1);
  assign home_ok = at_home && !posx_q[0] && !houses_q[posx_q];
  assign collide = lane_q[posy_q][posx_q] || (at_home && !home_ok);

  always_comb begin
    state_d  = state_q;
    presc_d  = (!run || tick) ? '0 : presc_q + PW'(1);
    posx_d   = posx_q;
    posy_d   = posy_q;
    lives_d  = lives_q;
    score_d  = score_q;
    houses_d = houses_q;
    level_d  = level_q;
    blink_d  = blink_q;
    load     = 1'b0;
    clr      = 1'b0;
    case (state_q)
      S_IDLE: if (jp.JP_START) begin
        state_d  = S_PLAY;
        load     = 1'b1;
        lives_d  = LW'(LIVES);
        score_d  = '0;
        houses_d = '0;
        level_d  = jp.JP_LEVEL;
        posx_d   = XW'(COLS / 2);
        posy_d   = '0;
      end
      S_PLAY: begin
        if (collide) begin
          lives_d = lives_q - LW'(1);
          state_d = (lives_q == LW'(1)) ? S_LOSE : S_DIE;
          presc_d = '0;
          blink_d = 1'b1;
        end else if (home_ok) begin
          houses_d[posx_q] = 1'b1;
          if (score_q != {SCOREW{1'b1}}) score_d = score_q + SCOREW'(1);
          posx_d = XW'(COLS / 2);
          posy_d = '0;
          if (houses_d == EVEN) state_d = S_WIN;
        end else if (one_mv) begin
          if (jp.JP_LEFT  && posx_q != '0)             posx_d = posx_q - XW'(1);
          if (jp.JP_RIGHT && posx_q != XW'(COLS - 1))  posx_d = posx_q + XW'(1);
          if (jp.JP_UP    && posy_q != YW'(ROWS - 1))  posy_d = posy_q + YW'(1);
          if (jp.JP_DOWN  && posy_q != '0)             posy_d = posy_q - YW'(1);
        end
      end
      S_DIE: if (tick) begin
        state_d = S_PLAY;
        clr     = 1'b1;
        posx_d  = XW'(COLS / 2);
        posy_d  = '0;
      end
      S_LOSE: begin
        if (jp.JP_START) state_d = S_IDLE;
        else if (tick)   blink_d = ~blink_q;
      end
      S_WIN: if (jp.JP_START) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Paint from next-state values so the matrix lines up with the other registered outputs.
  always_comb begin
    rows  = lane_d;
    mat_d = '0;
    if (state_d != S_IDLE) begin
      rows[ROWS-1] = houses_d;
      if (state_d inside {S_PLAY, S_WIN} || (state_d inside {S_DIE, S_LOSE} && blink_d))
        rows[posy_d][posx_d] = 1'b1;
      mat_d = rows;
    end
  end

  always_ff @(posedge JP_CLOCK) begin
    if (!JP_RESET) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      posx_q   <= XW'(COLS / 2);
      posy_q   <= '0;
      lives_q  <= LW'(LIVES);
      score_q  <= '0;
      houses_q <= '0;
      level_q  <= '0;
      blink_q  <= 1'b0;
      mat_q    <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      posx_q   <= posx_d;
      posy_q   <= posy_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      houses_q <= houses_d;
      level_q  <= level_d;
      blink_q  <= blink_d;
      mat_q    <= mat_d;
    end
  end

  assign jp.JP_MATRIX_OUT = mat_q;
  assign jp.JP_STATE_OUT  = state_q;
  assign jp.JP_POSX_OUT   = posx_q;
  assign jp.JP_POSY_OUT   = posy_q;
  assign jp.JP_LIVES_OUT  = lives_q;
  assign jp.JP_SCORE_OUT  = score_q;
endmodule
